// File: rtl/scale_shift_pipe.sv
// Two-stage multi-lane signed scaler: arithmetic right shift with optional
// round-half-up, saturating left shift, valid/ready flow control and sat counter.
module scale_shift_pipe #(
  parameter int unsigned N     = 4,
  parameter int unsigned LANES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*(1<<N)-1:0] in_data,
  input  logic [N:0]              in_shift,
  input  logic                    in_rnd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*(1<<N)-1:0] out_data,
  output logic [LANES-1:0]        out_sat,
  input  logic                    sat_clr,
  output logic [15:0]             sat_cnt
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned DW = LANES * W;
  localparam int unsigned SW = N + 1;
  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = 16;

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [DW-1:0]     s1_data_q,  s1_data_d;
  logic [SW-1:0]     s1_shift_q, s1_shift_d;
  logic              s1_rnd_q,   s1_rnd_d;
  logic              s1_dir_r_q, s1_dir_r_d;
  logic              s1_dir_l_q, s1_dir_l_d;
  logic [LANES-1:0]  s1_rbit_q,  s1_rbit_d;
  logic [LANES-1:0]  s1_sat_q,   s1_sat_d;

  // Stage 2 (output) state
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q,  out_data_d;
  logic [LANES-1:0]  out_sat_q,   out_sat_d;
  logic [CW-1:0]     sat_cnt_q,   sat_cnt_d;

  // Decode results and datapath
  logic              dir_r_c;
  logic              dir_l_c;
  logic [SW-1:0]     shift_neg_c;
  logic [N-1:0]      rbit_idx_c;
  logic [LANES-1:0]  rbit_c;
  logic [LANES-1:0]  sat_c;
  logic [DW-1:0]     y_c;
  logic              s2_adv_c;
  logic              s1_adv_c;

  // Stage 1 decode: direction, round bit (bit k-1 of x) and left-shift overflow
  always_comb begin : s1_decode
    logic [W-1:0]  x;
    logic [W2-1:0] prod;
    x           = '0;
    prod        = '0;
    rbit_c      = '0;
    sat_c       = '0;
    dir_l_c     = in_shift[N];
    dir_r_c     = !in_shift[N] && (in_shift != '0);
    shift_neg_c = SW'(0) - in_shift;
    rbit_idx_c  = in_shift[N-1:0] - N'(1);
    for (int unsigned i = 0; i < LANES; i++) begin
      x    = in_data[i*W +: W];
      prod = {{W{x[W-1]}}, x} << shift_neg_c;
      rbit_c[i] = x[rbit_idx_c];
      // Product fits in W bits only if it equals the sign extension of its low half
      sat_c[i]  = dir_l_c && (prod != {{W{prod[W-1]}}, prod[W-1:0]});
    end
  end

  // Stage 2 datapath: apply the shift chosen in stage 1
  always_comb begin : s2_compute
    logic [W-1:0]        x;
    logic signed [W-1:0] rs;
    logic [N-1:0]        amt_r;
    logic [SW-1:0]       amt_l;
    x     = '0;
    rs    = '0;
    y_c   = '0;
    amt_r = s1_shift_q[N-1:0];
    amt_l = SW'(0) - s1_shift_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      x  = s1_data_q[i*W +: W];
      rs = $signed(x) >>> amt_r;
      if (s1_sat_q[i]) begin
        y_c[i*W +: W] = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else if (s1_dir_l_q) begin
        y_c[i*W +: W] = x << amt_l;
      end else if (s1_dir_r_q) begin
        y_c[i*W +: W] = rs + W'(s1_rnd_q & s1_rbit_q[i]);
      end else begin
        y_c[i*W +: W] = x;
      end
    end
  end

  // Flow control and next-state
  always_comb begin : next_state
    s2_adv_c    = !out_valid_q || out_ready;
    s1_adv_c    = !s1_valid_q || s2_adv_c;
    in_ready    = s1_adv_c;

    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_shift_d  = s1_shift_q;
    s1_rnd_d    = s1_rnd_q;
    s1_dir_r_d  = s1_dir_r_q;
    s1_dir_l_d  = s1_dir_l_q;
    s1_rbit_d   = s1_rbit_q;
    s1_sat_d    = s1_sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_cnt_d   = sat_cnt_q;

    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d  = in_data;
        s1_shift_d = in_shift;
        s1_rnd_d   = in_rnd;
        s1_dir_r_d = dir_r_c;
        s1_dir_l_d = dir_l_c;
        s1_rbit_d  = rbit_c;
        s1_sat_d   = sat_c;
      end
    end

    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = y_c;
        out_sat_d  = s1_sat_q;
      end
    end

    // Clear takes priority; the counter sticks at all-ones
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && out_ready && (|out_sat_q) && (sat_cnt_q != {CW{1'b1}})) begin
      sat_cnt_d = sat_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_shift_q  <= '0;
      s1_rnd_q    <= 1'b0;
      s1_dir_r_q  <= 1'b0;
      s1_dir_l_q  <= 1'b0;
      s1_rbit_q   <= '0;
      s1_sat_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_shift_q  <= s1_shift_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_dir_r_q  <= s1_dir_r_d;
      s1_dir_l_q  <= s1_dir_l_d;
      s1_rbit_q   <= s1_rbit_d;
      s1_sat_q    <= s1_sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
